// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB multi-slave master.
package apb_pkg;

    localparam int APB_ADDR_WIDTH     = 32;
    localparam int APB_DATA_WIDTH     = 32;
    localparam int APB_MAX_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_state_e;

    // rdata is sized for the widest supported bus; the top uses the low bits
    typedef struct packed {
        logic [APB_MAX_DATA_WIDTH-1:0] rdata;
        logic                          err;
        logic                          timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_addr_decoder.sv
// Address to one-hot slave select, flagging indices beyond the slave count.
module apb_addr_decoder #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 8,
    parameter int SEL_LSB    = 12
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_SLAVES-1:0] psel,
    output logic                  err
);

    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [IW:0] NS = (IW + 1)'(NUM_SLAVES);

    logic [IW-1:0] idx;
    logic          unused_addr;

    assign idx         = addr[SEL_LSB +: IW];
    assign err         = ({1'b0, idx} >= NS);
    assign unused_addr = ^addr;

    always_comb begin
        psel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            psel[i] = !err && (idx == i[IW-1:0]);
        end
    end

endmodule

// File: rtl/apb_multi_slave_master.sv
// Single-outstanding APB master: request/response handshake to N slaves
// with address decode, wait-state timeout and registered bus outputs.
module apb_multi_slave_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int NUM_SLAVES = 8,
    parameter int SEL_LSB    = 12,
    parameter int TIMEOUT    = 255
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [NUM_SLAVES-1:0] psel,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  pwrite,
    output logic                  penable,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    apb_state_e            state_q, state_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic                  penable_q, penable_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    apb_rsp_t              rsp_q, rsp_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  run_q;

    logic [NUM_SLAVES-1:0] dec_psel;
    logic                  dec_err;
    logic                  unused_rdata;

    apb_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_LSB    (SEL_LSB)
    ) u_dec (
        .addr (req_addr),
        .psel (dec_psel),
        .err  (dec_err)
    );

    // run_q keeps req_ready low until the first edge after reset release
    assign req_ready    = run_q && (state_q == ST_IDLE);
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_rdata    = rsp_q.rdata[DATA_WIDTH-1:0];
    assign rsp_err      = rsp_q.err;
    assign rsp_timeout  = rsp_q.timeout;
    assign psel         = psel_q;
    assign paddr        = paddr_q;
    assign pwrite       = pwrite_q;
    assign penable      = penable_q;
    assign pwdata       = pwdata_q;
    assign unused_rdata = ^rsp_q.rdata;

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        penable_d = penable_q;
        pwdata_d  = pwdata_q;
        rsp_d     = rsp_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_wdata;
                    rsp_d    = '0;
                    if (dec_err) begin
                        rsp_d.err = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        psel_d  = dec_psel;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    rsp_d.err     = pslverr;
                    rsp_d.timeout = 1'b0;
                    rsp_d.rdata   = '0;
                    if (!pwrite_q && !pslverr) begin
                        rsp_d.rdata = APB_MAX_DATA_WIDTH'(prdata);
                    end
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        rsp_d.err     = 1'b1;
                        rsp_d.timeout = 1'b1;
                        rsp_d.rdata   = '0;
                        psel_d        = '0;
                        penable_d     = 1'b0;
                        state_d       = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            psel_q    <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            pwdata_q  <= '0;
            rsp_q     <= '0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            penable_q <= penable_d;
            pwdata_q  <= pwdata_d;
            rsp_q     <= rsp_d;
            cnt_q     <= cnt_d;
            run_q     <= 1'b1;
        end
    end

endmodule
